// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement,
// whole-line refill, uncached window at 0xA000_0000-0xBFFF_FFFF and a one-set-per-cycle flush.
module icache_nway #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAYS_LOG2    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_inst_req,
    input  logic [31:0] cpu_inst_addr,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    input  logic        flush,
    output logic        flush_busy,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WW   = OFFSET_WIDTH - 2;
    localparam int W    = 1 << WW;
    localparam int WAYS = 1 << WAYS_LOG2;
    localparam int TAGW = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int PW   = (WAYS_LOG2 > 0) ? WAYS_LOG2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_UNCACHED, S_FLUSH} state_t;
    state_t state_q, state_d;

    logic [WAYS-1:0]        valid_q [SETS];
    logic [PW-1:0]          ptr_q   [SETS];
    logic [TAGW-1:0]        tag_q   [SETS][WAYS];
    logic [31:0]            data_q  [SETS][WAYS][W];
    logic [31:0]            buf_q   [W];
    logic [31:0]            laddr_q;
    logic [PW-1:0]          victim_q;
    logic                   use_ptr_q;
    logic [WW-1:0]          cnt_q;
    logic                   wait_q;
    logic                   pend_q;
    logic [INDEX_WIDTH-1:0] fidx_q;

    logic [TAGW-1:0]        req_tag, ltag;
    logic [INDEX_WIDTH-1:0] req_idx, lidx;
    logic [WW-1:0]          req_word, lword;
    logic                   uncached, hit, vic_ptr, mem_fire, mem_take, done;
    logic [31:0]            hit_data;
    logic [PW-1:0]          vic;
    logic                   unused_addr_bits;

    assign req_tag  = cpu_inst_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
    assign req_idx  = cpu_inst_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign req_word = cpu_inst_addr[OFFSET_WIDTH-1:2];
    assign ltag     = laddr_q[31:INDEX_WIDTH+OFFSET_WIDTH];
    assign lidx     = laddr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
    assign lword    = laddr_q[OFFSET_WIDTH-1:2];
    assign uncached = (cpu_inst_addr[31:29] == 3'b101);
    assign unused_addr_bits = ^cpu_inst_addr[1:0];

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit      = 1'b1;
                hit_data = data_q[req_idx][w][req_word];
            end
        end
    end

    // Lowest invalid way wins; the round-robin pointer is used only for a full set.
    always_comb begin
        vic     = ptr_q[req_idx];
        vic_ptr = 1'b1;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (vic_ptr && !valid_q[req_idx][w]) begin
                vic     = PW'(w);
                vic_ptr = 1'b0;
            end
        end
    end

    // A data beat counts when awaited, or when it arrives with its own address acceptance.
    assign mem_fire = cache_inst_req && cache_inst_addr_ok;
    assign mem_take = (state_q == S_REFILL || state_q == S_UNCACHED) && cache_inst_data_ok
                      && (wait_q || mem_fire);
    assign done     = mem_take && (state_q == S_UNCACHED || cnt_q == WW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (flush)                  state_d = S_FLUSH;
                else if (cpu_inst_req) begin
                    if (uncached)           state_d = S_UNCACHED;
                    else if (!hit)          state_d = S_REFILL;
                end
            end
            S_REFILL, S_UNCACHED: begin
                if (done) state_d = (pend_q || flush) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (fidx_q == '1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_inst_addr_ok = 1'b0;
        cpu_inst_data_ok = 1'b0;
        cpu_inst_rdata   = '0;
        cache_inst_req   = 1'b0;
        cache_inst_addr  = {laddr_q[31:OFFSET_WIDTH], cnt_q, 2'b00};
        flush_busy       = (state_q == S_FLUSH) || pend_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_inst_req && !flush && !uncached && hit) begin
                    cpu_inst_addr_ok = 1'b1;
                    cpu_inst_data_ok = 1'b1;
                    cpu_inst_rdata   = hit_data;
                end
            end
            S_REFILL: begin
                cache_inst_req   = !wait_q;
                cpu_inst_addr_ok = done;
                cpu_inst_data_ok = done;
                cpu_inst_rdata   = (lword == cnt_q) ? cache_inst_rdata : buf_q[lword];
            end
            S_UNCACHED: begin
                cache_inst_req   = !wait_q;
                cache_inst_addr  = laddr_q;
                cpu_inst_addr_ok = done;
                cpu_inst_data_ok = done;
                cpu_inst_rdata   = cache_inst_rdata;
            end
            default: ;
        endcase
    end

    assign cache_inst_wr   = 1'b0;
    assign cache_inst_size = 2'b10;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            pend_q <= 1'b0;
            cnt_q  <= '0;
            wait_q <= 1'b0;
            fidx_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    laddr_q   <= cpu_inst_addr;
                    victim_q  <= vic;
                    use_ptr_q <= vic_ptr;
                    cnt_q     <= '0;
                    wait_q    <= 1'b0;
                end
                S_REFILL, S_UNCACHED: begin
                    if (mem_fire) wait_q <= 1'b1;
                    if (flush)    pend_q <= 1'b1;
                    if (mem_take) begin
                        wait_q       <= 1'b0;
                        buf_q[cnt_q] <= cache_inst_rdata;
                        cnt_q        <= cnt_q + 1'b1;
                    end
                    if (done) begin
                        pend_q <= 1'b0;
                        if (state_q == S_REFILL) begin
                            valid_q[lidx][victim_q] <= 1'b1;
                            if (use_ptr_q)
                                ptr_q[lidx] <= (victim_q == PW'(WAYS - 1)) ? '0 : victim_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    valid_q[fidx_q] <= '0;
                    ptr_q[fidx_q]   <= '0;
                    fidx_q          <= fidx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_REFILL && done) begin
            tag_q[lidx][victim_q] <= ltag;
            for (int unsigned k = 0; k < W; k++)
                data_q[lidx][victim_q][k] <= (k == W - 1) ? cache_inst_rdata : buf_q[k];
        end
    end
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (defaults: 128 sets, 4-word lines, 2 ways).
// Memory answers every accepted address one cycle later with (addr >> 2) ^ 32'hB0.
module tb_icache_nway;
    logic        clk = 1'b0;
    logic        rst, cpu_req, flush;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata, cache_addr;
    logic        cpu_addr_ok, cpu_data_ok, flush_busy;
    logic        cache_req, cache_wr;
    logic [1:0]  cache_size;
    logic [31:0] mem_rd = 32'h0;
    logic        mem_aok = 1'b1, mem_dok = 1'b0, mem_acc = 1'b0;
    logic [31:0] mem_paddr = 32'h0;
    logic [31:0] mem_log [0:511];
    int          mem_n = 0;
    int          checks = 0, errors = 0;

    icache_nway #(.INDEX_WIDTH(7), .OFFSET_WIDTH(4), .WAYS_LOG2(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_inst_req(cpu_req), .cpu_inst_addr(cpu_addr), .cpu_inst_rdata(cpu_rdata),
        .cpu_inst_addr_ok(cpu_addr_ok), .cpu_inst_data_ok(cpu_data_ok),
        .flush(flush), .flush_busy(flush_busy),
        .cache_inst_req(cache_req), .cache_inst_wr(cache_wr), .cache_inst_size(cache_size),
        .cache_inst_addr(cache_addr), .cache_inst_rdata(mem_rd),
        .cache_inst_addr_ok(mem_aok), .cache_inst_data_ok(mem_dok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        mem_acc = cache_req && mem_aok;
        if (mem_acc) begin
            mem_paddr = cache_addr;
            if (mem_n < 512) mem_log[mem_n] = cache_addr;
            mem_n++;
        end
    end

    always @(posedge clk) begin
        #1;
        mem_dok = mem_acc;
        mem_rd  = mem_acc ? ((mem_paddr >> 2) ^ 32'hB0) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_data,
                         input int exp_lat, input string tag);
        bit got;
        int lat;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        got = 1'b0;
        lat = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (cpu_addr_ok) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk({tag, ".done"}, 32'(got), 32'd1);
        chk({tag, ".data_ok"}, 32'(cpu_data_ok), 32'd1);
        chk({tag, ".rdata"}, cpu_rdata, exp_data);
        chk({tag, ".lat"}, lat, exp_lat);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        int base, fb, lat;
        bit got, aok_seen;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.addr_ok", 32'(cpu_addr_ok), 32'd0);
        chk("rst.data_ok", 32'(cpu_data_ok), 32'd0);
        chk("rst.mem_req", 32'(cache_req), 32'd0);
        chk("rst.busy", 32'(flush_busy), 32'd0);
        chk("rst.wr", 32'(cache_wr), 32'd0);
        chk("rst.size", 32'(cache_size), 32'd2);

        // Cold miss, whole line refilled in order, then a same-cycle hit
        base = mem_n;
        fetch(32'h40, 32'hA0, 8, "cold40");
        chk("cold40.nreq", mem_n - base, 4);
        for (int k = 0; k < 4; k++) chk("cold40.maddr", mem_log[base + k], 32'h40 + 32'(4 * k));
        base = mem_n;
        fetch(32'h48, 32'hA2, 0, "hit48");
        fetch(32'h4C, 32'hA3, 0, "hit4C");
        chk("hit.nreq", mem_n - base, 0);

        // Three tags on set 4: A=0x40 (way0), B=0x840 (way1), C=0x1040 evicts A
        fetch(32'h840, 32'h2A0, 8, "fillB");
        fetch(32'h1040, 32'h4A0, 8, "fillC");
        fetch(32'h840, 32'h2A0, 0, "hitB");
        fetch(32'h40, 32'hA0, 8, "missA");
        fetch(32'h1040, 32'h4A0, 0, "hitC");
        fetch(32'h840, 32'h2A0, 8, "missB");

        // Uncached window: never allocated
        base = mem_n;
        fetch(32'hBFC0_0000, 32'h2FF0_00B0, 2, "unc1");
        fetch(32'hBFC0_0000, 32'h2FF0_00B0, 2, "unc2");
        chk("unc.nreq", mem_n - base, 2);
        chk("unc.maddr0", mem_log[base], 32'hBFC0_0000);
        chk("unc.maddr1", mem_log[base + 1], 32'hBFC0_0000);

        // Flush during refill: refill completes, then 128 flush cycles
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h80;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fr.busy_mid", 32'(flush_busy), 32'd1);
        chk("fr.no_early_ok", 32'(cpu_addr_ok), 32'd0);
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (cpu_addr_ok) got = 1'b1;
        end
        chk("fr.done", 32'(got), 32'd1);
        chk("fr.data_ok", 32'(cpu_data_ok), 32'd1);
        chk("fr.rdata", cpu_rdata, 32'h90);
        @(posedge clk); #1 cpu_req = 1'b0;
        fb = 0;
        aok_seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!flush_busy) break;
            fb++;
            if (cpu_addr_ok || cpu_data_ok || cache_req) aok_seen = 1'b1;
        end
        chk("fr.busy_cycles", fb, 128);
        chk("fr.quiet", 32'(aok_seen), 32'd0);
        fetch(32'h48, 32'hA2, 8, "postflush48");
        fetch(32'h80, 32'h90, 8, "postflush80");

        // Flush and request in the same idle cycle
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h40; flush = 1'b1;
        @(negedge clk);
        chk("fq.no_ok", 32'(cpu_addr_ok), 32'd0);
        chk("fq.busy0", 32'(flush_busy), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("fq.busy1", 32'(flush_busy), 32'd1);
        got = 1'b0;
        lat = 0;
        for (int n = 2; n < 400 && !got; n++) begin
            @(negedge clk);
            if (cpu_addr_ok) begin
                got = 1'b1;
                lat = n;
            end
        end
        chk("fq.done", 32'(got), 32'd1);
        chk("fq.lat", lat, 137);
        chk("fq.rdata", cpu_rdata, 32'hA0);
        @(posedge clk); #1 cpu_req = 1'b0;

        // Reset after the second refill word: no partial line survives
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'hC0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        base = mem_n;
        @(negedge clk);
        chk("mr.addr_ok", 32'(cpu_addr_ok), 32'd0);
        chk("mr.data_ok", 32'(cpu_data_ok), 32'd0);
        chk("mr.mem_req", 32'(cache_req), 32'd0);
        chk("mr.busy", 32'(flush_busy), 32'd0);
        fetch(32'hC0, 32'h80, 8, "afterrst");
        chk("mr.nreq", mem_n - base, 4);
        chk("mr.maddr0", mem_log[base], 32'hC0);
        chk("mr.maddr3", mem_log[base + 3], 32'hCC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
